// File: rtl/clk_tick_gen.sv
// Multi-channel programmable tick/square-wave generator.
// Divisor updates go through a shadow register and take effect at a period boundary.
module clk_tick_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int DIV_RST = 100000,
  parameter int CH_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o
);

  localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RST);
  localparam logic [CH_W:0]    NUM_CH_C  = (CH_W+1)'(NUM_CH);

  logic [CNT_W-1:0]  cnt_r     [NUM_CH];
  logic [CNT_W-1:0]  div_act_r [NUM_CH];
  logic [CNT_W-1:0]  div_shd_r [NUM_CH];
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] tick_r;
  logic [NUM_CH-1:0] sq_r;
  logic              cfg_err_r;

  logic [CNT_W-1:0]  cnt_nx_s [NUM_CH];
  logic [CNT_W-1:0]  act_nx_s [NUM_CH];
  logic [CNT_W-1:0]  shd_nx_s [NUM_CH];
  logic [NUM_CH-1:0] pend_nx_s;
  logic [NUM_CH-1:0] tick_nx_s;
  logic [NUM_CH-1:0] sq_nx_s;
  logic              cfg_ok_s;
  logic              cfg_bad_s;

  // Write qualification: channel must exist and divisor must be at least 2.
  always_comb begin
    cfg_ok_s  = cfg_we && ({1'b0, cfg_ch} < NUM_CH_C) && (cfg_div >= CNT_W'(2));
    cfg_bad_s = cfg_we && !cfg_ok_s;
  end

  // Per-channel next state; priority is sync, then disable, then wrap, then count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      logic wr_hit;
      logic wrap;
      wr_hit       = cfg_ok_s && (cfg_ch == CH_W'(i));
      wrap         = (cnt_r[i] == div_act_r[i] - CNT_W'(1));
      cnt_nx_s[i]  = cnt_r[i];
      act_nx_s[i]  = div_act_r[i];
      shd_nx_s[i]  = wr_hit ? cfg_div : div_shd_r[i];
      pend_nx_s[i] = pend_r[i];
      tick_nx_s[i] = 1'b0;
      if (sync_i) begin
        cnt_nx_s[i]  = '0;
        pend_nx_s[i] = 1'b0;
        if (wr_hit) begin
          act_nx_s[i] = cfg_div;
        end else if (pend_r[i]) begin
          act_nx_s[i] = div_shd_r[i];
        end else begin
          act_nx_s[i] = div_act_r[i];
        end
      end else if (!en_i[i]) begin
        cnt_nx_s[i]  = '0;
        act_nx_s[i]  = pend_r[i] ? div_shd_r[i] : div_act_r[i];
        pend_nx_s[i] = wr_hit;
      end else if (wrap) begin
        // The wrap consumes the old shadow; a same-cycle write waits for the next wrap.
        cnt_nx_s[i]  = '0;
        tick_nx_s[i] = 1'b1;
        act_nx_s[i]  = pend_r[i] ? div_shd_r[i] : div_act_r[i];
        pend_nx_s[i] = wr_hit;
      end else begin
        cnt_nx_s[i]  = cnt_r[i] + CNT_W'(1);
        pend_nx_s[i] = pend_r[i] | wr_hit;
      end
      sq_nx_s[i] = (cnt_nx_s[i] >= (act_nx_s[i] >> 1));
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]     <= '0;
        div_act_r[i] <= DIV_RST_C;
        div_shd_r[i] <= DIV_RST_C;
      end
      pend_r    <= '0;
      tick_r    <= '0;
      sq_r      <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]     <= cnt_nx_s[i];
        div_act_r[i] <= act_nx_s[i];
        div_shd_r[i] <= shd_nx_s[i];
      end
      pend_r    <= pend_nx_s;
      tick_r    <= tick_nx_s;
      sq_r      <= sq_nx_s;
      cfg_err_r <= cfg_bad_s;
    end
  end

  assign tick_o  = tick_r;
  assign sq_o    = sq_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench for clk_tick_gen: directed scenarios followed by random traffic,
// all outputs compared every cycle against a period/age reference model.
module tb_clk_tick_gen;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int DIV_RST = 10;
  localparam int CH_W    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_CH-1:0] en_i = '0;
  logic              sync_i = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] sq_o;

  clk_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .sync_i(sync_i), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err), .tick_o(tick_o), .sq_o(sq_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int                cyc;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: how far into its period each channel is, the period length,
  // and the length queued for the next boundary (0 = nothing queued).
  int m_age    [NUM_CH];
  int m_len    [NUM_CH];
  int m_queued [NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_age[c]    = 0;
      m_len[c]    = DIV_RST;
      m_queued[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] en, input logic sy, input logic we,
                            input int ch, input int dv);
    exp_t e;
    bit   ok;
    bit   wr;
    ok     = we && (ch < NUM_CH) && (dv >= 2);
    e.cyc  = cyc + 1;
    e.err  = we && !ok;
    e.tick = '0;
    e.sq   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr = ok && (ch == c);
      if (sy) begin
        m_age[c] = 0;
        if (wr) m_len[c] = dv;
        else if (m_queued[c] != 0) m_len[c] = m_queued[c];
        m_queued[c] = 0;
      end else if (!en[c]) begin
        m_age[c] = 0;
        if (m_queued[c] != 0) m_len[c] = m_queued[c];
        m_queued[c] = wr ? dv : 0;
      end else begin
        m_age[c]++;
        if (m_age[c] == m_len[c]) begin
          m_age[c]  = 0;
          e.tick[c] = 1'b1;
          if (m_queued[c] != 0) begin
            m_len[c]    = m_queued[c];
            m_queued[c] = 0;
          end
        end
        if (wr) m_queued[c] = dv;
      end
      e.sq[c] = (m_age[c] >= m_len[c] / 2);
    end
    sb_q.push_back(e);
  endtask

  // One clock of stimulus; rst=0 holds the design in reset for this cycle.
  task automatic drive(input logic [NUM_CH-1:0] en, input logic sy, input logic we,
                       input int ch, input int dv, input logic rst);
    exp_t z;
    @(posedge clk);
    #2;
    en_i    = en;
    sync_i  = sy;
    cfg_we  = we;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(dv);
    if (!rst) begin
      if (rst_n) begin
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_sq", 32'(sq_o), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
      end
      model_reset();
      z.cyc  = cyc + 1;
      z.tick = '0;
      z.sq   = '0;
      z.err  = 1'b0;
      sb_q.push_back(z);
    end else begin
      rst_n = 1'b1;
      model_step(en, sy, we, ch, dv);
    end
  endtask

  task automatic idle(input logic [NUM_CH-1:0] en, input int n);
    for (int k = 0; k < n; k++) drive(en, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  // Monitor: compares the prediction for the edge that just happened.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      if (sb_q[0].cyc < cyc) begin
        mon_e = sb_q.pop_front();
        check("stale_prediction", 32'(mon_e.cyc), 32'(cyc));
      end else if (sb_q[0].cyc == cyc) begin
        mon_e = sb_q.pop_front();
        check("tick_o", 32'(tick_o), 32'(mon_e.tick));
        check("sq_o", 32'(sq_o), 32'(mon_e.sq));
        check("cfg_err", 32'(cfg_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] r_en;
    int                rst_left;
    int                stale;
    model_reset();
    // Reset and default period of 10.
    drive(4'hF, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(4'hF, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(4'hF, 24);
    // ch1 -> 5 mid-period.
    drive(4'hF, 1'b0, 1'b1, 1, 5, 1'b1);
    idle(4'hF, 20);
    // Rejected writes: channel out of range, divisor too small.
    drive(4'hF, 1'b0, 1'b1, 5, 7, 1'b1);
    idle(4'hF, 2);
    drive(4'hF, 1'b0, 1'b1, 0, 1, 1'b1);
    idle(4'hF, 12);
    // ch2 -> 7, ch3 -> 3, then sync.
    drive(4'hF, 1'b0, 1'b1, 2, 7, 1'b1);
    drive(4'hF, 1'b0, 1'b1, 3, 3, 1'b1);
    idle(4'hF, 20);
    drive(4'hF, 1'b1, 1'b0, 0, 0, 1'b1);
    idle(4'hF, 12);
    // ch0 disabled for 13 cycles while reprogrammed to 4.
    idle(4'hE, 5);
    drive(4'hE, 1'b0, 1'b1, 0, 4, 1'b1);
    idle(4'hE, 7);
    idle(4'hF, 12);
    // Write coinciding with sync, and reset mid-period.
    drive(4'hF, 1'b1, 1'b1, 2, 6, 1'b1);
    idle(4'hF, 7);
    drive(4'hF, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(4'hF, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(4'hF, 22);
    // Random traffic.
    r_en     = 4'hF;
    rst_left = 0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 39) == 0) r_en = NUM_CH'($urandom);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      drive(r_en, ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 5), $urandom_range(0, 12), (rst_left == 0));
    end
    idle(r_en, 3);
    @(negedge clk);
    #1;
    stale = 0;
    foreach (sb_q[k]) if (sb_q[k].cyc <= cyc) stale++;
    check("scoreboard_drain", 32'(stale), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
- Multi-channel programmable clock/tick generator. Successor to the fixed three-output divider.
- Each channel divides clk by a runtime-programmable integer divisor of 2 or more, odd divisors included. Each channel produces a registered square wave and a one-cycle tick strobe.
- Feeds debounce, PWM, timer and display-scan logic from one shared block.
- Per-channel enables, glitch-free divisor updates and a global phase-sync input.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 32, counter and divisor width in bits.
- DIV_RST, 100000, divisor loaded into every channel at reset (1 ms at 100 MHz).
- CH_W, 4, width of the channel-select field; requires 2^CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en_i  in  NUM_CH  per-channel run enable, level-sensitive.
- sync_i  in  1  one-cycle pulse; restarts all channels in phase.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_div  in  CNT_W  new divisor value.
- cfg_err  out  1  one-cycle pulse; the write was rejected.
- tick_o  out  NUM_CH  per-channel one-cycle strobe, once per period.
- sq_o  out  NUM_CH  per-channel square wave, period equal to the divisor.

Behaviour:
- Reset (async, rst_n=0): per channel, cnt=0, div_act=DIV_RST, div_shd=DIV_RST, pend=0. Outputs tick_o=0, sq_o=0, cfg_err=0.
- Per-channel state: cnt, div_act (active divisor), div_shd (shadow divisor), pend (update pending). All outputs are registered.
- Counting, when en_i[i]=1 and sync_i=0:
  - cnt counts 0..div_act-1.
  - At cnt==div_act-1, next cnt=0. If pend=1, div_act<=div_shd and pend<=0 on that same edge.
- tick_o[i]: registered. High for exactly the one cycle in which cnt==0 following a wrap. Never asserted on the first cycle after an enable rise or a sync.
- sq_o[i]: registered, equal to (cnt_next >= div_act_next>>1), so it is aligned with cnt.
  - Even divisor N: low N/2 cycles, high N/2 cycles.
  - Odd divisor N: low floor(N/2) cycles, high ceil(N/2) cycles.
- Disabled channel (en_i[i]=0): cnt held at 0, tick_o[i]=0, sq_o[i]=0.
  - A pending shadow value is applied immediately: div_act<=div_shd, pend<=0.
  - On enable rise, counting starts from cnt=0 on the next edge; the first period is full length.
- Config write (cfg_we=1):
  - Accepted if cfg_ch<NUM_CH and cfg_div>=2: div_shd[cfg_ch]<=cfg_div, pend<=1.
  - A running channel applies the new divisor at its next wrap, so no truncated or stretched period is ever produced.
  - A disabled channel applies it on the next edge.
  - Rejected if cfg_ch>=NUM_CH or cfg_div<2: no state change; cfg_err=1 for the following cycle.
  - A second write before the wrap overwrites div_shd; only the last value is applied.
- Sync (sync_i=1):
  - All channels: cnt<=0; div_act<=div_shd where pend=1; pend<=0.
  - tick_o=0 that cycle. sq_o follows the cnt=0 rule (0).
  - Sync has priority over a simultaneous wrap.
  - A write accepted in the same cycle as sync is applied by that sync.
- Wrap coinciding with a write to the same channel: the wrap applies the old shadow. The new value becomes pending and is applied at the following wrap.
- Counter never exceeds div_act-1; no overflow is possible since div_act <= 2^CNT_W-1.
- Reset asserted mid-period: all state returns to reset values at once; programmed divisors are lost.

Test Plan:
- Setup: NUM_CH=4, DIV_RST=10, all en_i=1, reset released.
  - Required: each tick_o pulses every 10 cycles, all channels in phase.
  - Required: sq_o is 5 cycles low then 5 cycles high.
  - Required: no tick on the first cycle after enable.
- Write ch1 div=5 mid-period:
  - Required: current 10-cycle period completes.
  - Required: then ticks every 5 cycles, sq_o[1] low 2 / high 3.
  - Required: cfg_err stays 0.
- Write ch5 (out of range), then ch0 div=1:
  - Required: cfg_err pulses one cycle after each write.
  - Required: ch0 keeps period 10; no other output changes.
- ch2 set to div=7, ch3 to div=3; run 20 cycles; pulse sync_i:
  - Required: all cnt=0 in the next cycle; no tick that cycle.
  - Required: next ticks at +7 for ch2, +3 for ch3 and +10 for ch0, counted from the sync edge.
- en_i[0] low 13 cycles while writing div=4 to ch0, then high:
  - Required: tick_o[0]/sq_o[0] stay 0 while low.
  - Required: after enable, first tick 4 cycles later, period 4.
- Assert rst_n low mid-period with ch1 at div=5:
  - Required: all outputs 0 immediately.
  - Required: after release, ch1 runs at period 10.
